tdm_mixer: RTL and testbench

Time-multiplexed voice mixer sitting directly downstream of `tdm_mul`. It consumes the packed per-voice products and sums all `NUM_UNITS` voices into one output sample. The sum is formed with a single adder over `NUM_UNITS` cycles of `ctl_clk`, then scaled and saturated to the DAC sample width. A new mix is started by a one-cycle sample request, issued once per audio sample period.

---
 rtl/tdm_mixer_if.sv | 30 +++
 rtl/tdm_mixer.sv | 132 +++++++++++++
 tb/tb_tdm_mixer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tdm_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mixer_if
// Brief    : Bus bundle between the voice source and the TDM voice mixer.
// Revision : 1.0 - initial release
// ============================================================================
interface tdm_mixer_if #(
    parameter int C_WIDTH   = 32,
    parameter int NUM_UNITS = 8,
    parameter int OUT_WIDTH = 16
) ();
    logic [C_WIDTH*NUM_UNITS-1:0] products;
    logic                         sample_req;
    logic [OUT_WIDTH-1:0]         mix_out;
    logic                         mix_valid;
    logic                         busy;
    logic                         clip;
    logic                         overrun;

    modport master (
        output products, sample_req,
        input  mix_out, mix_valid, busy, clip, overrun
    );

    modport slave (
        input  products, sample_req,
        output mix_out, mix_valid, busy, clip, overrun
    );
endinterface
`default_nettype wire

// File: rtl/tdm_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mixer
// Brief    : Sums NUM_UNITS snapshotted voice products with one adder, then
//            scales by SHIFT. Define TDM_MIXER_SAT_EN to saturate the output
//            (otherwise two's-complement wrap, clip tied low).
// Revision : 1.0 - initial release
// ============================================================================
module tdm_mixer #(
    parameter int C_WIDTH   = 32,
    parameter int NUM_UNITS = 8,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8
) (
    input  wire logic       ctl_clk,
    input  wire logic       ctl_rst,
    tdm_mixer_if.slave      bus
);
    localparam int c_acc_w = C_WIDTH + $clog2(NUM_UNITS) + 1;
    localparam int c_idx_w = $clog2(NUM_UNITS);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_UNITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic signed [C_WIDTH-1:0]   w_prod [NUM_UNITS];
    logic signed [C_WIDTH-1:0]   r_snap [NUM_UNITS];
    logic signed [c_acc_w-1:0]   r_acc;
    logic        [c_idx_w-1:0]   r_idx;
    logic        [OUT_WIDTH-1:0] r_mix_out;
    logic                        r_mix_valid;
    logic                        r_clip;
    logic                        r_overrun;

    logic signed [C_WIDTH-1:0]   w_voice;
    logic signed [c_acc_w-1:0]   w_total;
    logic signed [c_acc_w-1:0]   w_scaled;
    logic        [OUT_WIDTH-1:0] w_out;
    logic                        w_clip;
    logic                        w_last;
    logic                        w_start;

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unpack
            assign w_prod[gi] = bus.products[C_WIDTH*gi +: C_WIDTH];
        end
    endgenerate

    assign w_voice  = r_snap[r_idx];
    assign w_total  = r_acc + {{(c_acc_w-C_WIDTH){w_voice[C_WIDTH-1]}}, w_voice};
    assign w_scaled = w_total >>> SHIFT;
    assign w_start  = (r_state == ST_IDLE) && bus.sample_req;
    assign w_last   = (r_state == ST_ACCUM) && (r_idx == c_idx_last);

`ifdef TDM_MIXER_SAT_EN
    localparam logic signed [c_acc_w-1:0] c_sat_max =
        {{(c_acc_w-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_sat_min =
        {{(c_acc_w-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
        w_out  = w_scaled[OUT_WIDTH-1:0];
        w_clip = 1'b0;
        if (w_scaled > c_sat_max) begin
            w_out  = c_sat_max[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end else if (w_scaled < c_sat_min) begin
            w_out  = c_sat_min[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end
    end
`else
    // Upper bits are intentionally discarded: the output wraps.
    logic w_unused_hi;
    assign w_unused_hi = ^w_scaled[c_acc_w-1:OUT_WIDTH];
    assign w_out       = w_scaled[OUT_WIDTH-1:0];
    assign w_clip      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.sample_req) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (r_idx == c_idx_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk) begin
        if (!ctl_rst) begin
            r_state     <= ST_IDLE;
            r_snap      <= '{default: '0};
            r_acc       <= '0;
            r_idx       <= '0;
            r_mix_out   <= '0;
            r_mix_valid <= 1'b0;
            r_clip      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mix_valid <= 1'b0;
            if (w_start) begin
                r_snap <= w_prod;
                r_acc  <= '0;
                r_idx  <= '0;
            end
            if (r_state == ST_ACCUM) begin
                r_acc <= w_total;
                r_idx <= r_idx + 1'b1;
                // Requests during a mix are dropped, never queued.
                if (bus.sample_req) r_overrun <= 1'b1;
            end
            if (w_last) begin
                r_idx       <= '0;
                r_mix_out   <= w_out;
                r_clip      <= w_clip;
                r_mix_valid <= 1'b1;
            end
        end
    end

    assign bus.mix_out   = r_mix_out;
    assign bus.mix_valid = r_mix_valid;
    assign bus.busy      = (r_state == ST_ACCUM);
    assign bus.clip      = r_clip;
    assign bus.overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_tdm_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_mixer
// Brief    : Directed self-checking bench for tdm_mixer at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_mixer;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    tdm_mixer_if #(.C_WIDTH(32), .NUM_UNITS(N), .OUT_WIDTH(16)) bus ();

    tdm_mixer #(.C_WIDTH(32), .NUM_UNITS(N), .OUT_WIDTH(16), .SHIFT(8)) u_dut (
        .ctl_clk (clk),
        .ctl_rst (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < N; i++) bus.products[32*i +: 32] = v;
    endtask

    // Entered #1 after a rising edge. Fires a request, optionally overwrites
    // the products after chg_at cycles and fires a second request at req2_at.
    task automatic run_mix(input int chg_at, input logic [31:0] chg_val, input int req2_at,
                           output int lat, output int nvalid,
                           output logic [15:0] res, output logic res_clip);
        lat = -1; nvalid = 0; res = '0; res_clip = 1'b0;
        bus.sample_req = 1'b1;
        @(posedge clk); #1;
        bus.sample_req = 1'b0;
        check("busy_after_req", 64'(bus.busy), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            if (chg_at > 0 && i - 1 == chg_at) set_all(chg_val);
            bus.sample_req = (req2_at > 0 && i == req2_at);
            @(posedge clk); #1;
            if (bus.mix_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat      = i;
                    res      = bus.mix_out;
                    res_clip = bus.clip;
                end
            end
        end
        bus.sample_req = 1'b0;
    endtask

    int          lat, nv;
    logic [15:0] res;
    logic        rc;
    logic [15:0] exp_pos, exp_neg;
    logic        exp_pclip, exp_nclip;

    initial begin
`ifdef TDM_MIXER_SAT_EN
        exp_pos = 16'h7FFF; exp_pclip = 1'b1;
        exp_neg = 16'h8000; exp_nclip = 1'b1;
`else
        exp_pos = 16'h0000; exp_pclip = 1'b0;
        exp_neg = 16'h0000; exp_nclip = 1'b0;
`endif
        bus.sample_req = 1'b0;
        bus.products   = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mix_out",   64'(bus.mix_out),   64'd0);
        check("rst_mix_valid", 64'(bus.mix_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_clip",      64'(bus.clip),      64'd0);
        check("rst_overrun",   64'(bus.overrun),   64'd0);

        // 8 * 0x100 = 0x800, >>> 8 = 8
        set_all(32'h0000_0100);
        run_mix(0, '0, 0, lat, nv, res, rc);
        check("basic_latency", 64'(lat), 64'(N));
        check("basic_nvalid",  64'(nv),  64'd1);
        check("basic_out",     64'(res), 64'h0008);
        check("basic_clip",    64'(rc),  64'd0);
        check("basic_busy_end",64'(bus.busy), 64'd0);
        check("basic_hold",    64'(bus.mix_out), 64'h0008);

        // 0x1000 - 0x1000 + 0xA00 = 0xA00 -> 0xA; late change must be ignored
        bus.products = '0;
        bus.products[31:0]  = 32'h0000_1000;
        bus.products[63:32] = 32'hFFFF_F000;
        bus.products[95:64] = 32'h0000_0A00;
        run_mix(2, 32'h7FFF_FFFF, 0, lat, nv, res, rc);
        check("sign_latency", 64'(lat), 64'(N));
        check("sign_out",     64'(res), 64'h000A);
        check("sign_clip",    64'(rc),  64'd0);

        // 8 * 0x0100_0000 >>> 8 = 0x0008_0000
        set_all(32'h0100_0000);
        run_mix(0, '0, 0, lat, nv, res, rc);
        check("pos_out",  64'(res), 64'(exp_pos));
        check("pos_clip", 64'(rc),  64'(exp_pclip));

        set_all(32'hFF00_0000);
        run_mix(0, '0, 0, lat, nv, res, rc);
        check("neg_out",  64'(res), 64'(exp_neg));
        check("neg_clip", 64'(rc),  64'(exp_nclip));
        check("pre_overrun", 64'(bus.overrun), 64'd0);

        // Second request 3 cycles into the mix is dropped
        set_all(32'h0000_0100);
        run_mix(0, '0, 3, lat, nv, res, rc);
        check("ovr_nvalid",  64'(nv),  64'd1);
        check("ovr_latency", 64'(lat), 64'(N));
        check("ovr_out",     64'(res), 64'h0008);
        check("ovr_flag",    64'(bus.overrun), 64'd1);
        check("ovr_busy_end",64'(bus.busy), 64'd0);

        // Reset in the middle of a mix
        set_all(32'h0000_0200);
        bus.sample_req = 1'b1;
        @(posedge clk); #1;
        bus.sample_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_out",     64'(bus.mix_out),   64'd0);
        check("mid_rst_valid",   64'(bus.mix_valid), 64'd0);
        check("mid_rst_busy",    64'(bus.busy),      64'd0);
        check("mid_rst_clip",    64'(bus.clip),      64'd0);
        check("mid_rst_overrun", 64'(bus.overrun),   64'd0);
        rst = 1'b1;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.mix_valid) nv++;
        end
        check("mid_no_valid", 64'(nv), 64'd0);

        // Recovery: 8 * 0x200 >>> 8 = 0x10
        run_mix(0, '0, 0, lat, nv, res, rc);
        check("recov_latency", 64'(lat), 64'(N));
        check("recov_out",     64'(res), 64'h0010);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
